// File: rtl/dcache_line_ctrl_pkg.sv
// Shared types and sizing helpers for the D-cache multi-word line miss controller.
package dcache_pkg;

  localparam int WORDS_PER_LINE_DEF = 4;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    WRITE_BACK = 2'd1,
    FILL       = 2'd2,
    REPLAY     = 2'd3
  } state_e;

  function automatic int idx_w(input int words);
    return (words > 1) ? $clog2(words) : 1;
  endfunction

endpackage

// File: rtl/dcache_line_ctrl_if.sv
// Pipeline/memory-facing signal bundle of dcache_line_ctrl.
// master = pipeline + memory side, slave = miss controller.
interface dcache_line_ctrl_if #(
  parameter int WORDS_PER_LINE = dcache_pkg::WORDS_PER_LINE_DEF
);
  localparam int IDX_W = dcache_pkg::idx_w(WORDS_PER_LINE);

  logic             user_use;
  logic             hit;
  logic             dirty;
  logic             drdy;
  logic [IDX_W-1:0] miss_word;
  logic             stall;
  logic             mem_re;
  logic             mem_we;
  logic             cache_re;
  logic             cache_we;
  logic [IDX_W-1:0] word_idx;
  logic             line_done;

  modport master (
    output user_use, hit, dirty, drdy, miss_word,
    input  stall, mem_re, mem_we, cache_re, cache_we, word_idx, line_done
  );

  modport slave (
    input  user_use, hit, dirty, drdy, miss_word,
    output stall, mem_re, mem_we, cache_re, cache_we, word_idx, line_done
  );
endinterface

// File: rtl/dcache_line_ctrl_line_word_ctr.sv
// Wrapping word index plus an extra-bit transfer count; load may coincide with
// inc so the detection cycle can already count its word.
module line_word_ctr
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  load,
  input  logic [idx_w(WORDS_PER_LINE)-1:0]      start,
  input  logic                                  inc,
  output logic [idx_w(WORDS_PER_LINE)-1:0]      idx,
  output logic                                  last
);
  localparam int IDX_W = idx_w(WORDS_PER_LINE);
  localparam int CNT_W = IDX_W + 1;

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
      cnt <= '0;
    end else if (load) begin
      idx <= start + IDX_W'(inc);
      cnt <= CNT_W'(inc);
    end else if (inc) begin
      idx <= idx + IDX_W'(1);
      cnt <= cnt + CNT_W'(1);
    end
  end

  // Completion is by words moved, so a wrapped start word does not matter.
  assign last = (cnt == CNT_W'(WORDS_PER_LINE - 1));

endmodule

// File: rtl/dcache_line_ctrl.sv
// D-cache miss controller: dirty write-back then word-by-word refill, one replay cycle.
// Optional DCACHE_CRITICAL_WORD_FIRST_EN starts the fill at miss_word and wraps.
module dcache_line_ctrl
  import dcache_pkg::*;
#(
  parameter int WORDS_PER_LINE = WORDS_PER_LINE_DEF
) (
  input logic               clk,
  input logic               rst_n,
  dcache_line_ctrl_if.slave bus
);
  localparam int IDX_W = idx_w(WORDS_PER_LINE);

  state_e           state_q, state_d;
  logic             ctr_load, ctr_inc, ctr_last;
  logic [IDX_W-1:0] ctr_start, ctr_idx;
  logic [IDX_W-1:0] idle_fill_start, wb_fill_start;
  logic             miss;
  logic             stall, mem_re, mem_we, cache_re, cache_we, line_done;
  logic [IDX_W-1:0] word_idx;

  // Gated by rst_n so every output is 0 for the whole reset pulse.
  assign miss = bus.user_use & ~bus.hit & rst_n;

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  logic [IDX_W-1:0] crit_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      crit_q <= '0;
    else if (state_q == IDLE && miss) crit_q <= bus.miss_word;
  end

  assign idle_fill_start = bus.miss_word;
  assign wb_fill_start   = crit_q;
`else
  logic unused_miss_word;
  assign unused_miss_word = ^bus.miss_word;
  assign idle_fill_start  = '0;
  assign wb_fill_start    = '0;
`endif

  line_word_ctr #(.WORDS_PER_LINE(WORDS_PER_LINE)) u_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (ctr_load),
    .start (ctr_start),
    .inc   (ctr_inc),
    .idx   (ctr_idx),
    .last  (ctr_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    ctr_load  = 1'b0;
    ctr_inc   = 1'b0;
    ctr_start = '0;
    stall     = 1'b0;
    mem_re    = 1'b0;
    mem_we    = 1'b0;
    cache_re  = 1'b0;
    cache_we  = 1'b0;
    line_done = 1'b0;
    word_idx  = ctr_idx;
    case (state_q)
      IDLE: begin
        // The detection cycle is already the first transfer cycle.
        if (miss) begin
          stall    = 1'b1;
          ctr_load = 1'b1;
          ctr_inc  = bus.drdy;
          if (bus.dirty) begin
            mem_we   = 1'b1;
            cache_re = 1'b1;
            state_d  = WRITE_BACK;
          end else begin
            mem_re    = 1'b1;
            cache_we  = bus.drdy;
            ctr_start = idle_fill_start;
            state_d   = FILL;
          end
        end
        word_idx = ctr_start;
      end
      WRITE_BACK: begin
        stall    = 1'b1;
        mem_we   = 1'b1;
        cache_re = 1'b1;
        if (bus.drdy) begin
          if (ctr_last) begin
            ctr_load  = 1'b1;
            ctr_start = wb_fill_start;
            state_d   = FILL;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      FILL: begin
        stall    = 1'b1;
        mem_re   = 1'b1;
        cache_we = bus.drdy;
        if (bus.drdy) begin
          if (ctr_last) begin
            ctr_load = 1'b1;
            state_d  = REPLAY;
          end else begin
            ctr_inc = 1'b1;
          end
        end
      end
      REPLAY: begin
        stall     = 1'b1;
        line_done = 1'b1;
        ctr_load  = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.stall     = stall;
  assign bus.mem_re    = mem_re;
  assign bus.mem_we    = mem_we;
  assign bus.cache_re  = cache_re;
  assign bus.cache_we  = cache_we;
  assign bus.word_idx  = word_idx;
  assign bus.line_done = line_done;

endmodule

// File: tb/tb_dcache_line_ctrl.sv
// Bench for dcache_line_ctrl: queue-based miss model checked every cycle, plus
// directed scenarios with hand-computed literal expectations.
module tb_dcache_line_ctrl;
  localparam int W  = 4;
  localparam int IW = $clog2(W);

`ifdef DCACHE_CRITICAL_WORD_FIRST_EN
  localparam bit CWF = 1'b1;
`else
  localparam bit CWF = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dcache_line_ctrl_if #(.WORDS_PER_LINE(W)) bus ();

  dcache_line_ctrl #(.WORDS_PER_LINE(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] outs();
    return {bus.stall, bus.mem_re, bus.mem_we, bus.cache_re, bus.cache_we, bus.line_done};
  endfunction

  // Model: a miss becomes a queue of write-back words and a queue of fill
  // words; each drdy consumes the head, then one replay cycle follows.
  int wb_q[$];
  int fill_q[$];
  bit replay_due = 1'b0;

  always @(negedge clk) begin : model_cmp
    logic [5:0] e;
    int         e_idx;
    int         s;
    bit         fill_done;
    e = '0; e_idx = 0; fill_done = 1'b0;
    if (!rst_n) begin
      wb_q.delete();
      fill_q.delete();
      replay_due = 1'b0;
      check("reset_outs", {26'd0, outs()}, 32'd0);
      check("reset_idx", {{(32-IW){1'b0}}, bus.word_idx}, 32'd0);
    end else begin
      if (wb_q.size() == 0 && fill_q.size() == 0 && !replay_due && bus.user_use && !bus.hit) begin
        s = CWF ? int'(bus.miss_word) : 0;
        if (bus.dirty) for (int i = 0; i < W; i++) wb_q.push_back(i);
        for (int i = 0; i < W; i++) fill_q.push_back((s + i) % W);
      end
      if (wb_q.size() != 0) begin
        e = 6'b101100;
        e_idx = wb_q[0];
        if (bus.drdy) void'(wb_q.pop_front());
      end else if (fill_q.size() != 0) begin
        e = {1'b1, 1'b1, 1'b0, 1'b0, bus.drdy, 1'b0};
        e_idx = fill_q[0];
        if (bus.drdy) begin
          void'(fill_q.pop_front());
          fill_done = (fill_q.size() == 0);
        end
      end else if (replay_due) begin
        e = 6'b100001;
        replay_due = 1'b0;
      end
      if (fill_done) replay_due = 1'b1;
      check("model_outs", {26'd0, outs()}, {26'd0, e});
      check("model_idx", {{(32-IW){1'b0}}, bus.word_idx}, e_idx);
    end
  end

  task automatic drive(input logic u, input logic h, input logic d, input logic dr, input int mw);
    @(posedge clk);
    #1;
    bus.user_use  = u;
    bus.hit       = h;
    bus.dirty     = d;
    bus.drdy      = dr;
    bus.miss_word = IW'(mw);
    @(negedge clk);
  endtask

  int obs_stalls, obs_mwe, obs_done;
  int obs_order[$];

  task automatic sample();
    if (bus.stall)     obs_stalls++;
    if (bus.mem_we)    obs_mwe++;
    if (bus.line_done) obs_done++;
    if (bus.cache_we)  obs_order.push_back(int'(bus.word_idx));
  endtask

  // One miss; drdy is high on every per-th cycle counting the detection cycle as 0.
  task automatic run_miss(input logic d, input int mw, input int per);
    int k;
    obs_stalls = 0; obs_mwe = 0; obs_done = 0; obs_order.delete();
    k = 0;
    drive(1'b1, 1'b0, d, (per == 1), mw);
    sample();
    while (bus.stall && k < 100) begin
      k++;
      drive(1'b0, 1'b0, 1'b0, ((k % per) == per - 1), 0);
      sample();
    end
    check("miss_terminates", {31'd0, bus.stall}, 32'd0);
  endtask

  initial begin : watchdog
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got running, want done");
    $fatal(1);
  end

  initial begin : stim
    int cnt;
    int exp_order[4];
    bus.user_use = 1'b0; bus.hit = 1'b0; bus.dirty = 1'b0; bus.drdy = 1'b0; bus.miss_word = '0;

    // Reset state, with a would-be miss presented during reset.
    drive(1'b1, 1'b0, 1'b1, 1'b1, 0);
    check("rst_miss_masked", {26'd0, outs()}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Hit stream.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, W - 1));
      if (outs() != 6'd0 || bus.word_idx != '0) cnt++;
    end
    check("hit_stream_quiet", cnt, 0);

    // No access, tag mismatch.
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      drive(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b1, 0);
      if (bus.stall) cnt++;
    end
    check("no_use_no_stall", cnt, 0);

    // Clean miss, drdy every cycle.
    run_miss(1'b0, 0, 1);
    check("clean_stalls", obs_stalls, 5);
    check("clean_we_count", obs_order.size(), 4);
    for (int i = 0; i < 4; i++) check("clean_order", obs_order.size() > i ? obs_order[i] : -1, i);
    check("clean_line_done", obs_done, 1);

    // Dirty miss, drdy every third cycle.
    run_miss(1'b1, 0, 3);
    check("dirty_stalls", obs_stalls, 25);
    check("dirty_mem_we_cycles", obs_mwe, 12);
    check("dirty_we_count", obs_order.size(), 4);
    for (int i = 0; i < 4; i++) check("dirty_order", obs_order.size() > i ? obs_order[i] : -1, i);
    check("dirty_line_done", obs_done, 1);

    // miss_word=3: critical word first or ignored.
    exp_order = CWF ? '{3, 0, 1, 2} : '{0, 1, 2, 3};
    run_miss(1'b0, 3, 1);
    check("cwf_we_count", obs_order.size(), 4);
    for (int i = 0; i < 4; i++) check("cwf_order", obs_order.size() > i ? obs_order[i] : -1, exp_order[i]);
    check("cwf_stalls", obs_stalls, 5);

    // Reset during FILL word 2.
    drive(1'b1, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b1, 0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    check("fill_word2_idx", {{(32-IW){1'b0}}, bus.word_idx}, 2);
    check("fill_word2_outs", {26'd0, outs()}, {26'd0, 6'b110000});
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_outs", {26'd0, outs()}, 32'd0);
    check("async_rst_idx", {{(32-IW){1'b0}}, bus.word_idx}, 0);
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
    run_miss(1'b0, 1, 1);
    check("post_rst_first_word", obs_order.size() > 0 ? obs_order[0] : -1, CWF ? 1 : 0);
    check("post_rst_stalls", obs_stalls, 5);

    // Random traffic, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        @(posedge clk); #3 rst_n = 1'b0;
        @(negedge clk);
        @(posedge clk); #1 rst_n = 1'b1;
      end
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 2) != 0), $urandom_range(0, W - 1));
    end

    drive(1'b0, 1'b0, 1'b0, 1'b0, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dcache_line_ctrl.md
# dcache_line_ctrl

Parametrised D-cache miss controller that handles multi-word cache lines. On a miss it stalls the pipeline, writes back a dirty victim line one word at a time, then refills the line word by word. It drives the word index that both the cache data array and the memory address mux use. It sits between the D-cache tag/data arrays and the unified memory interface, and it replaces the single-word miss FSM used in the D-cache.

## Interface
Parameters:
- WORDS_PER_LINE, 4, words per cache line; power of two, 2..16.
- IDX_W, $clog2(WORDS_PER_LINE), word-index width; derived, never overridden.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- user_use  input  1  pipeline is presenting a valid D-cache access this cycle.
- hit  input  1  tag match for the current access; sampled only in IDLE.
- dirty  input  1  victim line dirty bit; sampled only in IDLE on a miss.
- drdy  input  1  memory has completed the current word (read data valid, or write accepted).
- miss_word  input  IDX_W  word offset of the missing access; used only with the critical-word-first option.
- stall  output  1  freeze the pipeline.
- mem_re  output  1  memory read enable.
- mem_we  output  1  memory write enable.
- cache_re  output  1  read the victim word from the data array.
- cache_we  output  1  write the returned word into the data array.
- word_idx  output  IDX_W  word being transferred.
- line_done  output  1  one-cycle pulse when the refill completes.

## Operation
- States: IDLE, WRITE_BACK, FILL, REPLAY.
- IDLE:
  - All outputs 0.
  - user_use & ~hit & dirty -> WRITE_BACK, word counter = 0.
  - user_use & ~hit & ~dirty -> FILL, word counter = fill start word.
  - Otherwise stay in IDLE; drdy is ignored.
- Miss-cycle outputs: the IDLE cycle that detects a miss already drives stall=1, plus mem_we=cache_re=1 (dirty) or mem_re=1 (clean), with word_idx equal to the first word.
- WRITE_BACK:
  - Drives stall=1, mem_we=1, cache_re=1.
  - Each drdy advances the counter by 1.
  - drdy on word WORDS_PER_LINE-1 -> FILL, with the counter loaded with the fill start word.
- FILL:
  - Drives stall=1, mem_re=1.
  - cache_we = drdy, in the same cycle the data is valid.
  - Each drdy advances the counter modulo WORDS_PER_LINE (wrap-around).
  - The drdy that completes the WORDS_PER_LINE-th word -> REPLAY.
  - A separate transfer counter of IDX_W+1 bits tracks completion, independent of the start word.
- REPLAY:
  - One cycle with stall=1 and no enables, so the tag and data arrays settle.
  - line_done=1 in this cycle.
  - Always -> IDLE. The pipeline re-presents the access, which now hits.
- hit, dirty and miss_word are don't-care outside IDLE.
- word_idx outputs the counter in every state; it is 0 in IDLE.
- Reset (asserted at any time, including mid-transfer): state = IDLE, counters = 0, all outputs 0 immediately. The partially filled line is not retagged; the tag owner invalidates it.

## Timing
- All outputs are combinational from state and counter, plus drdy for cache_we and transitions. There are no output registers.
- Minimum stall for a clean miss with drdy held high: WORDS_PER_LINE+1 cycles (FILL words plus REPLAY).
- Minimum stall for a dirty miss: 2*WORDS_PER_LINE+1 cycles.
- The stall count also includes the IDLE detection cycle. That cycle counts as the first word of the transfer if drdy is high, because its transition happens on the next edge.
- Memory handshake: the enable is held continuously until the last drdy. The memory must present the next word on the following cycle at the earliest.
- A memory that returns drdy slowly just stretches the current state; there is no timeout.

## Configuration
- DCACHE_CRITICAL_WORD_FIRST_EN:
  - Defined: miss_word is latched in IDLE on a clean miss, or on a dirty miss for use after write-back. The fill starts at miss_word and wraps (for example 2,3,0,1 with 4 words).
  - Undefined: miss_word is ignored and the fill always runs 0..WORDS_PER_LINE-1.
  - Write-back always runs from word 0 regardless of the macro.

## Structure
- Package dcache_pkg holds:
  - the state enum (2 bits: IDLE=0, WRITE_BACK=1, FILL=2, REPLAY=3);
  - the WORDS_PER_LINE default;
  - the derived-width helper.
- One sub-module, line_word_ctr: an IDX_W-bit wrapping index plus an IDX_W+1-bit transfer count. It has load (start value), inc, and last outputs.

## Test plan
- Hit stream: user_use=1, hit=1 for 20 cycles -> stall and all enables stay 0, word_idx=0.
- Clean miss, WORDS_PER_LINE=4, drdy=1 every cycle -> mem_re for 4 cycles, cache_we with word_idx 0,1,2,3, then REPLAY with line_done=1, then IDLE.
- Dirty miss, drdy every 3rd cycle -> mem_we/cache_re with word_idx 0..3 each held 3 cycles, then FILL 0..3 in the same pattern; total stall 25 cycles.
- Critical-word-first build, clean miss with miss_word=3 -> fill order 3,0,1,2 and exactly 4 cache_we pulses.
- rst_n pulsed low during FILL word 2 -> all outputs 0 asynchronously; after release the block is in IDLE and the next miss starts at word 0 (or at miss_word in the critical-word-first build).
- Miss with user_use=0 (hit=0) -> no transition and no stall.
